// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// and the wait-counter width.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between the fetch and data requesters.
// Ports:
//   if_req, d_req  - pending requests
//   last_grant     - owner of the previous grant (round-robin build only)
//   owner          - selected owner (combinational; meaningful when a req is high)
// Build option ARB_ROUND_ROBIN_EN: alternate on contention; otherwise data wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_e last_grant,
    output owner_e owner
);

`ifdef ARB_ROUND_ROBIN_EN
    // On contention hand the port to whoever did not have it last time.
    always_comb begin
        owner = OWN_IF;
        if (if_req && d_req) begin
            owner = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end
`else
    // Fixed priority: data always wins; last_grant has no role here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        owner = OWN_IF;
        if (d_req) begin
            owner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch requester
// and a data requester. One transaction: IDLE -> ISSUE -> WAIT -> DONE.
// Ports:
//   clk, rst                               - clock, synchronous active-high reset
//   if_req/if_addr/if_ready/if_rdata       - fetch requester
//   d_req/d_we/d_addr/d_wdata/d_ready/d_rdata - data requester
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata - shared memory port
//   stall                                  - PC hold (combinational)
//   busy                                   - transaction in flight
// Build option ARB_ROUND_ROBIN_EN: round-robin grant on contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    state_e             state, state_n;
    owner_e             owner, owner_n, pick;
    owner_e             last_grant;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic               we_q, we_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic [DATA_W-1:0]  if_rdata_n, d_rdata_n;
    logic               grant;

    assign grant = (state == IDLE) && (if_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the previous grant so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IF;
        end else if (grant) begin
            last_grant <= pick;
        end
    end
`else
    assign last_grant = OWN_IF;
`endif

    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .owner      (pick)
    );

    // Next-state and latch/capture logic.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        cnt_n      = cnt;
        addr_n     = addr_q;
        we_n       = we_q;
        wdata_n    = wdata_q;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_n = ISSUE;
                    owner_n = pick;
                    if (pick == OWN_D) begin
                        addr_n  = d_addr;
                        we_n    = d_we;
                        wdata_n = d_wdata;
                    end else begin
                        addr_n  = if_addr;
                        we_n    = 1'b0;
                        wdata_n = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_n   = CNT_W'(MEM_LAT - 1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    // Writes leave the read-data registers untouched.
                    if (!we_q) begin
                        if (owner == OWN_D) d_rdata_n  = mem_rdata;
                        else                if_rdata_n = mem_rdata;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; port outputs are decoded from next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            addr_q    <= addr_n;
            we_q      <= we_n;
            wdata_q   <= wdata_n;
            if_rdata  <= if_rdata_n;
            d_rdata   <= d_rdata_n;
            if_ready  <= (state_n == DONE) && (owner_n == OWN_IF);
            d_ready   <= (state_n == DONE) && (owner_n == OWN_D);
            mem_addr  <= (state_n == ISSUE) ? addr_n  : '0;
            mem_wdata <= (state_n == ISSUE) ? wdata_n : '0;
            mem_re    <= (state_n == ISSUE) && !we_n;
            mem_we    <= (state_n == ISSUE) && we_n;
            busy      <= (state_n != IDLE);
        end
    end

    // PC hold drops only in the cycle the fetch result is delivered.
    assign stall = if_req && !((state == DONE) && (owner == OWN_IF));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        if_ready1, d_ready1, mem_re1, mem_we1, stall1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        if_ready4, d_ready4, mem_re4, mem_we4, stall4, busy4;
    logic [31:0] if_rdata4, d_rdata4, mem_addr4, mem_wdata4;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
        .stall(stall1), .busy(busy1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready4), .if_rdata(if_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready4), .d_rdata(d_rdata4),
        .mem_addr(mem_addr4), .mem_re(mem_re4), .mem_we(mem_we4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
        .stall(stall4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({if_ready1, d_ready1, if_rdata1, d_rdata1, mem_addr1, mem_re1, mem_we1,
             mem_wdata1, stall1, busy1} !== '0) begin
            bad++; $display("FAIL reset_dut1: outputs not all zero, if_rdata=%h mem_addr=%h busy=%b",
                            if_rdata1, mem_addr1, busy1);
        end
        total++;
        if ({if_ready4, d_ready4, if_rdata4, d_rdata4, mem_addr4, mem_re4, mem_we4,
             mem_wdata4, stall4, busy4} !== '0) begin
            bad++; $display("FAIL reset_dut4: outputs not all zero, if_rdata=%h mem_addr=%h busy=%b",
                            if_rdata4, mem_addr4, busy4);
        end
        if_req = 1'b1;
        #1;
        total++;
        if (stall1 !== 1'b1) begin
            bad++; $display("FAIL reset_stall: got %b exp 1", stall1);
        end
        if_req = 1'b0;
        #1;
    endtask

    task automatic test_fetch();
        logic [3:0] e_re, e_rdy, e_stall, e_busy;
        e_re = 4'b0010; e_rdy = 4'b1000; e_stall = 4'b0111; e_busy = 4'b1110;
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            total++;
            if ({mem_re1, if_ready1, stall1, busy1} !== {e_re[c], e_rdy[c], e_stall[c], e_busy[c]}) begin
                bad++; $display("FAIL fetch_cycle%0d: re/rdy/stall/busy got %b%b%b%b exp %b%b%b%b", c,
                                mem_re1, if_ready1, stall1, busy1, e_re[c], e_rdy[c], e_stall[c], e_busy[c]);
            end
            if (c == 1) begin
                total++;
                if (mem_addr1 !== 32'h10 || mem_we1 !== 1'b0) begin
                    bad++; $display("FAIL fetch_issue: mem_addr=%h we=%b exp 00000010 0", mem_addr1, mem_we1);
                end
            end
            if (c == 3) begin
                total++;
                if (if_rdata1 !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL fetch_rdata: got %h exp deadbeef", if_rdata1);
                end
                if_req = 1'b0;
            end
        end
        tick();
        total++;
        if (if_ready1 !== 1'b0 || busy1 !== 1'b0 || if_rdata1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fetch_after: ready=%b busy=%b rdata=%h exp 0 0 deadbeef",
                            if_ready1, busy1, if_rdata1);
        end
    endtask

    task automatic test_data_read();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_rdata = 32'h5555AAAA;
        #1;
        tick(); tick(); tick();
        total++;
        if (d_ready1 !== 1'b1 || if_ready1 !== 1'b0 || d_rdata1 !== 32'h5555AAAA) begin
            bad++; $display("FAIL dread_done: d_ready=%b if_ready=%b d_rdata=%h exp 1 0 5555aaaa",
                            d_ready1, if_ready1, d_rdata1);
        end
        total++;
        if (if_rdata1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL dread_if_hold: if_rdata=%h exp deadbeef", if_rdata1);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; mem_rdata = 32'hBAD0BAD0;
        #1;
        tick();
        total++;
        if ({mem_we1, mem_re1} !== 2'b10 || mem_addr1 !== 32'h40 || mem_wdata1 !== 32'h1234) begin
            bad++; $display("FAIL write_issue: we=%b re=%b addr=%h wdata=%h exp 1 0 00000040 00001234",
                            mem_we1, mem_re1, mem_addr1, mem_wdata1);
        end
        // Requester drops out and scribbles its inputs after the grant.
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h9999;
        tick();
        total++;
        if ({mem_we1, mem_re1} !== 2'b00 || mem_addr1 !== '0 || mem_wdata1 !== '0) begin
            bad++; $display("FAIL write_wait: we=%b re=%b addr=%h wdata=%h exp all zero",
                            mem_we1, mem_re1, mem_addr1, mem_wdata1);
        end
        tick();
        total++;
        if (d_ready1 !== 1'b1 || d_rdata1 !== 32'h5555AAAA) begin
            bad++; $display("FAIL write_done: d_ready=%b d_rdata=%h exp 1 5555aaaa", d_ready1, d_rdata1);
        end
        tick();
        total++;
        if (d_ready1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL write_after: d_ready=%b busy=%b exp 0 0", d_ready1, busy1);
        end
    endtask

    task automatic test_both();
        logic [31:0] exp_addr [4];
        int exp_if, exp_d, exp_slow;
        int n_if, n_d, n_slow;
`ifdef ARB_ROUND_ROBIN_EN
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h100; exp_addr[2] = 32'h200; exp_addr[3] = 32'h100;
        exp_if = 2; exp_d = 2; exp_slow = 2;
`else
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h200; exp_addr[2] = 32'h200; exp_addr[3] = 32'h200;
        exp_if = 0; exp_d = 4; exp_slow = 0;
`endif
        n_if = 0; n_d = 0; n_slow = 0;
        do_reset();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h100; d_addr = 32'h200;
        mem_rdata = 32'h77;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            if (c % 4 == 1) begin
                total++;
                if (mem_addr1 !== exp_addr[c / 4]) begin
                    bad++; $display("FAIL both_grant%0d: mem_addr=%h exp %h", c / 4, mem_addr1, exp_addr[c / 4]);
                end
            end
            if (if_ready1 === 1'b1) n_if++;
            if (d_ready1 === 1'b1) n_d++;
            if (stall1 === 1'b0) n_slow++;
            if (c == 15) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        total++;
        if (n_if !== exp_if) begin
            bad++; $display("FAIL both_if_ready: count %0d exp %0d", n_if, exp_if);
        end
        total++;
        if (n_d !== exp_d) begin
            bad++; $display("FAIL both_d_ready: count %0d exp %0d", n_d, exp_d);
        end
        total++;
        if (n_slow !== exp_slow) begin
            bad++; $display("FAIL both_stall_low: count %0d exp %0d", n_slow, exp_slow);
        end
        tick();
    endtask

    task automatic test_lat4();
        do_reset();
        if_req = 1'b1; if_addr = 32'h20; mem_rdata = 32'h11111111;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            total++;
            if (if_ready4 !== ((c == 6) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL lat4_ready_cycle%0d: got %b", c, if_ready4);
            end
            if (c == 1) begin
                total++;
                if (mem_re4 !== 1'b1 || mem_addr4 !== 32'h20) begin
                    bad++; $display("FAIL lat4_issue: re=%b addr=%h exp 1 00000020", mem_re4, mem_addr4);
                end
            end
            if (c >= 2 && c <= 4) mem_rdata = 32'h11110000 + 32'(c);
            if (c == 5) mem_rdata = 32'hCAFEF00D;
            if (c == 6) begin
                total++;
                if (if_rdata4 !== 32'hCAFEF00D) begin
                    bad++; $display("FAIL lat4_rdata: got %h exp cafef00d", if_rdata4);
                end
                if_req = 1'b0; mem_rdata = 32'h0BADF00D;
            end
        end
        tick();
        total++;
        if (if_ready4 !== 1'b0 || if_rdata4 !== 32'hCAFEF00D) begin
            bad++; $display("FAIL lat4_hold: ready=%b rdata=%h exp 0 cafef00d", if_ready4, if_rdata4);
        end
    endtask

    task automatic test_rst_in_wait();
        int n_rdy;
        n_rdy = 0;
        if_req = 1'b1; if_addr = 32'h30; mem_rdata = 32'h12345678;
        #1;
        tick(); tick(); tick();
        total++;
        if (busy4 !== 1'b1) begin
            bad++; $display("FAIL rstwait_busy_before: got %b exp 1", busy4);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({busy4, if_ready4, mem_re4, stall4} !== 4'b0001 || if_rdata4 !== '0) begin
            bad++; $display("FAIL rstwait_after: busy/ready/re/stall=%b%b%b%b rdata=%h exp 0001 0",
                            busy4, if_ready4, mem_re4, stall4, if_rdata4);
        end
        rst = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if_ready4 === 1'b1) n_rdy++;
        end
        total++;
        if (n_rdy !== 0) begin
            bad++; $display("FAIL rstwait_no_ready: count %0d exp 0", n_rdy);
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'hA5A5A5A5;
        #1;
        tick();
        total++;
        if (mem_addr4 !== 32'h40 || mem_re4 !== 1'b1) begin
            bad++; $display("FAIL achg_issue: addr=%h re=%b exp 00000040 1", mem_addr4, mem_re4);
        end
        tick();
        d_addr = 32'h80;
        for (int c = 2; c < 6; c++) begin
            if (c > 2) tick();
            total++;
            if (mem_addr4 !== '0 || mem_re4 !== 1'b0) begin
                bad++; $display("FAIL achg_wait%0d: addr=%h re=%b exp 0 0", c, mem_addr4, mem_re4);
            end
        end
        tick();
        total++;
        if (d_ready4 !== 1'b1 || d_rdata4 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL achg_done: d_ready=%b d_rdata=%h exp 1 a5a5a5a5", d_ready4, d_rdata4);
        end
        d_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_data_read();
        test_write();
        test_both();
        test_lat4();
        test_rst_in_wait();
        test_addr_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
